// File: rtl/float_stream_out_pkg.sv
// float_stream_out shared types and constants.
// Word geometry, FSM encoding and the float zero test.
package float_stream_out_pkg;

    localparam int WIDTH  = 32;
    localparam int NWORDS = 6;
    localparam int IDXW   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Sign bit is ignored so -0.0 and +0.0 both count as zero.
    function automatic logic is_zero(input logic [WIDTH-1:0] w);
        return (w[WIDTH-2:0] == '0);
    endfunction

endpackage

// File: rtl/float_stream_out_if.sv
// Single-word valid/ready stream carrying data, slot index and last flag.
// The master drives the beat; the slave returns ready.
interface float_stream_out_if;
    import float_stream_out_pkg::*;

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic [IDXW-1:0]  index;
    logic             last;

    modport master (
        output valid,
        output data,
        output index,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  index,
        input  last,
        output ready
    );

endinterface

// File: rtl/float_stream_out_next_slot_sel.sv
// Combinational search for the lowest eligible slot at or above i_from.
// A slot is eligible unless skipping is on and its word is zero.
module next_slot_sel
    import float_stream_out_pkg::*;
(
    input  logic [NWORDS-1:0] i_zmask,
    input  logic              i_skip,
    input  logic [IDXW-1:0]   i_from,
    output logic [IDXW-1:0]   o_idx,
    output logic              o_found
);

    // Scan downward so the lowest matching slot is the one left standing.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = NWORDS - 1; k >= 0; k--) begin
            if ((IDXW'(k) >= i_from) && (!i_skip || !i_zmask[k])) begin
                o_idx   = IDXW'(k);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/float_stream_out.sv
// Snapshots six float words and drains them as an indexed stream,
// optionally dropping +/-0.0 words.
module float_stream_out
    import float_stream_out_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_skip_zero,
    input  logic [WIDTH-1:0]  i_in0,
    input  logic [WIDTH-1:0]  i_in1,
    input  logic [WIDTH-1:0]  i_in2,
    input  logic [WIDTH-1:0]  i_in3,
    input  logic [WIDTH-1:0]  i_in4,
    input  logic [WIDTH-1:0]  i_in5,
    output logic              o_busy,
    output logic              o_done,
    output logic [IDXW-1:0]   o_nz_count,
    float_stream_out_if.master m_out
);

    state_t            r_state;
    logic [WIDTH-1:0]  r_snap [NWORDS];
    logic              r_skip;
    logic [IDXW-1:0]   r_ptr;
    logic              r_valid;
    logic [WIDTH-1:0]  r_data;
    logic              r_done;
    logic [IDXW-1:0]   r_nz_count;

    logic [WIDTH-1:0]  w_in [NWORDS];
    logic [NWORDS-1:0] w_in_zmask;
    logic [NWORDS-1:0] w_snap_zmask;
    logic [IDXW-1:0]   w_nz;
    logic [IDXW-1:0]   w_first_idx;
    logic              w_first_found;
    logic [IDXW-1:0]   w_adv_from;
    logic [IDXW-1:0]   w_adv_idx;
    logic              w_adv_found;
    logic              w_hs;

    assign w_in[0] = i_in0;
    assign w_in[1] = i_in1;
    assign w_in[2] = i_in2;
    assign w_in[3] = i_in3;
    assign w_in[4] = i_in4;
    assign w_in[5] = i_in5;

    always_comb begin
        w_nz = '0;
        for (int k = 0; k < NWORDS; k++) begin
            w_in_zmask[k]   = is_zero(w_in[k]);
            w_snap_zmask[k] = is_zero(r_snap[k]);
            w_nz = w_nz + {{(IDXW-1){1'b0}}, ~w_in_zmask[k]};
        end
    end

    next_slot_sel u_first (
        .i_zmask (w_in_zmask),
        .i_skip  (i_skip_zero),
        .i_from  ('0),
        .o_idx   (w_first_idx),
        .o_found (w_first_found)
    );

    assign w_adv_from = r_ptr + 3'd1;

    next_slot_sel u_adv (
        .i_zmask (w_snap_zmask),
        .i_skip  (r_skip),
        .i_from  (w_adv_from),
        .o_idx   (w_adv_idx),
        .o_found (w_adv_found)
    );

    assign w_hs = r_valid & m_out.ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_snap     <= '{default: '0};
            r_skip     <= 1'b0;
            r_ptr      <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_nz_count <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_snap     <= w_in;
                        r_skip     <= i_skip_zero;
                        r_nz_count <= w_nz;
                        if (w_first_found) begin
                            r_state <= ST_SEND;
                            r_ptr   <= w_first_idx;
                            r_data  <= w_in[w_first_idx];
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (w_hs) begin
                        if (w_adv_found) begin
                            r_ptr  <= w_adv_idx;
                            r_data <= r_snap[w_adv_idx];
                        end else begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Last is derived from the pending lookahead so it tracks ptr exactly.
    assign m_out.valid = r_valid;
    assign m_out.data  = r_data;
    assign m_out.index = r_ptr & {IDXW{r_valid}};
    assign m_out.last  = r_valid & ~w_adv_found;

    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = r_done;
    assign o_nz_count = r_nz_count;

endmodule

// File: tb/tb_float_stream_out.sv
// Scoreboard bench for float_stream_out: directed vectors push
// expected beats, a negedge monitor pops and compares them.
module tb_float_stream_out;
    import float_stream_out_pkg::*;

    typedef struct packed {
        logic [2:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        skip_zero = 1'b0;
    logic [31:0] in_w [6];
    logic        busy;
    logic        done;
    logic [2:0]  nz_count;

    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    ready_mode = 0;
    beat_t sb [$];

    float_stream_out_if m_if ();

    float_stream_out dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_skip_zero (skip_zero),
        .i_in0       (in_w[0]),
        .i_in1       (in_w[1]),
        .i_in2       (in_w[2]),
        .i_in3       (in_w[3]),
        .i_in4       (in_w[4]),
        .i_in5       (in_w[5]),
        .o_busy      (busy),
        .o_done      (done),
        .o_nz_count  (nz_count),
        .m_out       (m_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = never ready.
    initial begin
        logic [3:0] pat;
        int bp;
        pat = 4'b1001;
        bp = 0;
        m_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: m_if.ready = 1'b1;
                1: begin
                    m_if.ready = pat[bp];
                    bp = (bp + 1) % 4;
                end
                default: m_if.ready = 1'b0;
            endcase
        end
    end

    // Monitor: beat compare on handshake, plus hold check across stalls.
    initial begin
        logic [31:0] pd;
        logic [2:0]  pi;
        bit          pst;
        beat_t       got;
        beat_t       exp;
        pst = 0;
        pd = '0;
        pi = '0;
        forever begin
            @(negedge clk);
            if (pst && !rst) begin
                n_cmp++;
                if (!m_if.valid || m_if.data !== pd || m_if.index !== pi) begin
                    n_err++;
                    $display("FAIL hold: valid=%0b data=%h idx=%0d, need 1 %h %0d",
                             m_if.valid, m_if.data, m_if.index, pd, pi);
                end
            end
            if (!rst && m_if.valid && m_if.ready) begin
                got = '{idx: m_if.index, data: m_if.data, last: m_if.last};
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL beat: unexpected idx=%0d data=%h last=%0b",
                             got.idx, got.data, got.last);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        n_err++;
                        $display("FAIL beat: got idx=%0d data=%h last=%0b, need idx=%0d data=%h last=%0b",
                                 got.idx, got.data, got.last, exp.idx, exp.data, exp.last);
                    end
                end
            end
            pst = !rst && m_if.valid && !m_if.ready;
            pd  = m_if.data;
            pi  = m_if.index;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, need %h", nm, act, req);
        end
    endtask

    task automatic push(input int idx, input logic [31:0] d, input bit l);
        sb.push_back('{idx: idx[2:0], data: d, last: l});
    endtask

    task automatic start_xfer(input bit skip, output int n0);
        @(posedge clk);
        #1;
        start = 1'b1;
        skip_zero = skip;
        @(posedge clk);
        #1;
        start = 1'b0;
        n0 = cyc;
    endtask

    // exp_t is cycles after the start-acceptance cycle; -1 skips the timing check.
    task automatic wait_done(input int n0, input int exp_t, input string nm);
        int t;
        bit got;
        got = 0;
        t = -1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                t = cyc - n0;
                check({nm, " busy@done"}, 64'(busy), 64'd1);
                check({nm, " valid@done"}, 64'(m_if.valid), 64'd0);
            end
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL %s done: timeout", nm);
        end else if (exp_t >= 0 && t != exp_t) begin
            n_err++;
            $display("FAIL %s done: at t=%0d, need t=%0d", nm, t, exp_t);
        end
        @(negedge clk);
        check({nm, " done/busy after"}, {62'd0, done, busy}, 64'd0);
    endtask

    task automatic check_sb(input string nm);
        check({nm, " leftover"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int n0;
        bit seen;
        for (int k = 0; k < 6; k++) in_w[k] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outs", {busy, done, nz_count, m_if.valid, m_if.data,
                             m_if.index, m_if.last}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full stream
        for (int k = 0; k < 6; k++) begin
            in_w[k] = 32'h3F800000 + 32'(k);
            push(k, 32'h3F800000 + 32'(k), k == 5);
        end
        start_xfer(1'b0, n0);
        wait_done(n0, 6, "full");
        check("full nz", 64'(nz_count), 64'd6);
        check_sb("full");

        // Maxnet winner, back-to-back start after done
        in_w[0] = 32'h00000000;
        in_w[1] = 32'h80000000;
        in_w[2] = 32'h00000000;
        in_w[3] = 32'h3E4CCCCD;
        in_w[4] = 32'h80000000;
        in_w[5] = 32'h00000000;
        push(3, 32'h3E4CCCCD, 1'b1);
        start_xfer(1'b1, n0);
        wait_done(n0, 1, "winner");
        check("winner nz", 64'(nz_count), 64'd1);
        check_sb("winner");

        // Empty transfer
        in_w[3] = 32'h80000000;
        start_xfer(1'b1, n0);
        wait_done(n0, 0, "empty");
        check("empty nz", 64'(nz_count), 64'd0);
        check_sb("empty");

        // Backpressure with a zero slot that is still emitted
        in_w[0] = 32'h40000000;
        in_w[1] = 32'h40400000;
        in_w[2] = 32'h80000000;
        in_w[3] = 32'hBF000000;
        in_w[4] = 32'h7F7FFFFF;
        in_w[5] = 32'h00000001;
        push(0, 32'h40000000, 1'b0);
        push(1, 32'h40400000, 1'b0);
        push(2, 32'h80000000, 1'b0);
        push(3, 32'hBF000000, 1'b0);
        push(4, 32'h7F7FFFFF, 1'b0);
        push(5, 32'h00000001, 1'b1);
        ready_mode = 1;
        start_xfer(1'b0, n0);
        wait_done(n0, -1, "bp");
        ready_mode = 0;
        check("bp nz", 64'(nz_count), 64'd5);
        check_sb("bp");

        // Interference: new inputs and start during SEND
        in_w[0] = 32'h3F800000;
        in_w[1] = 32'h00000000;
        in_w[2] = 32'hC0000000;
        in_w[3] = 32'h80000000;
        in_w[4] = 32'h40490FDB;
        in_w[5] = 32'h00000000;
        push(0, 32'h3F800000, 1'b0);
        push(2, 32'hC0000000, 1'b0);
        push(4, 32'h40490FDB, 1'b1);
        start_xfer(1'b1, n0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) in_w[k] = 32'h11111111;
        start = 1'b1;
        skip_zero = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n0, 3, "intf");
        repeat (3) @(negedge clk);
        check("intf idle", {62'd0, busy, m_if.valid}, 64'd0);
        check("intf nz", 64'(nz_count), 64'd3);
        check_sb("intf");

        // Reset mid-transfer after the index-2 beat
        for (int k = 0; k < 6; k++) in_w[k] = 32'h3F800000 + 32'(k);
        push(0, 32'h3F800000, 1'b0);
        push(1, 32'h3F800001, 1'b0);
        push(2, 32'h3F800002, 1'b0);
        start_xfer(1'b0, n0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        ready_mode = 2;
        @(negedge clk);
        check("pre-rst idx", 64'(m_if.index), 64'd3);
        @(negedge clk);
        check("rst outs", {busy, done, nz_count, m_if.valid, m_if.data,
                           m_if.index, m_if.last}, 64'd0);
        check_sb("rst");
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        check("rst no done", 64'(seen), 64'd0);

        for (int k = 0; k < 6; k++) push(k, 32'h3F800000 + 32'(k), k == 5);
        start_xfer(1'b0, n0);
        wait_done(n0, 6, "restart");
        check("restart nz", 64'(nz_count), 64'd6);
        check_sb("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
